// File: rtl/ahb_lite_sram_slave_if.sv
// ahb_lite_sram_slave_if
//   AHB-Lite bus bundle between one master/interconnect and the SRAM slave.
//   master modport: drives HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT,
//                   HMASTLOCK, HWDATA and the interconnect HREADY;
//                   observes HRDATA, HREADYOUT, HRESP.
//   slave modport:  the mirror image.
interface ahb_lite_sram_slave_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic                  HMASTLOCK;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
           HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
           HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave
//   AHB-Lite slave in front of a word-organised SRAM. Inserts WAIT_STATES
//   wait cycles per OKAY transfer, writes only the byte lanes selected by
//   HSIZE/HADDR, and answers size/alignment/range violations with a
//   two-cycle ERROR response without touching memory.
//   Ports:
//     HCLK   - clock, rising edge
//     HRESET - asynchronous active-high reset
//     bus    - AHB-Lite slave modport (HSEL..HREADY in, HRDATA/HREADYOUT/HRESP out)
module ahb_lite_sram_slave #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MEM_DEPTH   = 256,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 0
) (
  input logic                   HCLK,
  input logic                   HRESET,
  ahb_lite_sram_slave_if.slave  bus
);

  localparam int unsigned NB     = DATA_WIDTH / 8;
  localparam int unsigned LANE_W = $clog2(NB);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * NB);
  localparam logic [ADDR_WIDTH-1:0] ALL_ONES  = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [LANE_W-1:0]     r_lane;
  logic [2:0]            r_size;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] w_off;
  logic [ADDR_WIDTH-1:0] w_align_mask;
  logic                  w_size_err;
  logic                  w_misalign;
  logic                  w_range_err;
  logic                  w_err;
  logic                  w_can_accept;
  logic                  w_accept;
  logic                  w_hreadyout;
  logic                  w_hresp;
  logic [NB-1:0]         w_be;
  logic                  w_unused;

  // Address-phase checks
  assign w_off        = bus.HADDR - BASE_ADDR;
  assign w_align_mask = ~(ALL_ONES << bus.HSIZE);
  assign w_size_err   = bus.HSIZE > 3'(LANE_W);
  assign w_misalign   = |(bus.HADDR & w_align_mask);
  // Addresses below BASE_ADDR wrap to large offsets and are caught here too.
  assign w_range_err  = {1'b0, w_off} >= MEM_BYTES;
  assign w_err        = w_size_err | w_misalign | w_range_err;

  assign w_unused = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0]};

  always_comb begin
    w_next       = r_state;
    w_hreadyout  = 1'b1;
    w_hresp      = 1'b0;
    w_can_accept = 1'b0;
    case (r_state)
      ST_IDLE: w_can_accept = 1'b1;
      ST_WAIT: begin
        w_hreadyout = 1'b0;
        if (r_cnt <= 3'd1) w_next = ST_DATA;
      end
      ST_DATA: begin
        w_can_accept = 1'b1;
        w_next       = ST_IDLE;
      end
      ST_ERR1: begin
        w_hreadyout = 1'b0;
        w_hresp     = 1'b1;
        w_next      = ST_ERR2;
      end
      ST_ERR2: begin
        w_hresp      = 1'b1;
        w_can_accept = 1'b1;
        w_next       = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    w_accept = w_can_accept & bus.HSEL & bus.HREADY & bus.HTRANS[1];
    if (w_accept) begin
      if (w_err)                w_next = ST_ERR1;
      else if (WAIT_STATES > 0) w_next = ST_WAIT;
      else                      w_next = ST_DATA;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_lane  <= '0;
      r_size  <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_idx   <= w_off[LANE_W +: IDX_W];
        r_lane  <= bus.HADDR[LANE_W-1:0];
        r_size  <= bus.HSIZE;
        r_write <= bus.HWRITE;
      end
      if (w_accept && !w_err) r_cnt <= 3'(WAIT_STATES);
      else if (r_state == ST_WAIT) r_cnt <= r_cnt - 3'd1;
    end
  end

  // Lanes [r_lane, r_lane + 2^r_size) of the addressed word are written.
  always_comb begin
    w_be = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      w_be[b] = (b >= 32'(r_lane)) && (b < 32'(r_lane) + (32'd1 << r_size));
    end
  end

  // Write commits on the edge that ends DATA; a reset in flight leaves
  // the FSM out of DATA, so the pending write is dropped.
  always_ff @(posedge HCLK) begin
    if (!HRESET && r_state == ST_DATA && r_write) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (w_be[b]) r_mem[r_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  // Combinational read port: a read following a write to the same word
  // sees the committed data without a bypass path.
  assign bus.HRDATA    = (r_state == ST_DATA && !r_write) ? r_mem[r_idx] : '0;
  assign bus.HREADYOUT = w_hreadyout;
  assign bus.HRESP     = w_hresp;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
module tb_ahb_lite_sram_slave;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [63:0] wdata;
  } xfer_t;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        t_sel;
  logic [31:0] t_addr;
  logic [1:0]  t_trans;
  logic        t_write;
  logic [2:0]  t_size;
  logic [2:0]  t_burst;
  logic [63:0] t_wdata;
  logic        t_hready_low;
  int          t_dut;

  logic        o_ready;
  logic        o_resp;
  logic [63:0] o_rdata;
  logic        w_hready;

  int          n_assert = 0;
  int          n_fail   = 0;
  string       g_tag    = "init";
  logic [63:0] g_last_rd;
  logic [7:0]  mdl [3][2048];
  xfer_t       q[$];

  always #5 HCLK = ~HCLK;

  ahb_lite_sram_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if_a ();
  ahb_lite_sram_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if_b ();
  ahb_lite_sram_slave_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) if_c ();

  ahb_lite_sram_slave #(.DATA_WIDTH(32), .MEM_DEPTH(256), .ADDR_WIDTH(32),
                        .BASE_ADDR(32'h0), .WAIT_STATES(0))
    u_a (.HCLK(HCLK), .HRESET(HRESET), .bus(if_a));
  ahb_lite_sram_slave #(.DATA_WIDTH(32), .MEM_DEPTH(256), .ADDR_WIDTH(32),
                        .BASE_ADDR(32'h0), .WAIT_STATES(3))
    u_b (.HCLK(HCLK), .HRESET(HRESET), .bus(if_b));
  ahb_lite_sram_slave #(.DATA_WIDTH(64), .MEM_DEPTH(256), .ADDR_WIDTH(32),
                        .BASE_ADDR(32'h0), .WAIT_STATES(0))
    u_c (.HCLK(HCLK), .HRESET(HRESET), .bus(if_c));

  assign o_ready  = (t_dut == 0) ? if_a.HREADYOUT : (t_dut == 1) ? if_b.HREADYOUT : if_c.HREADYOUT;
  assign o_resp   = (t_dut == 0) ? if_a.HRESP     : (t_dut == 1) ? if_b.HRESP     : if_c.HRESP;
  assign o_rdata  = (t_dut == 0) ? {32'h0, if_a.HRDATA} :
                    (t_dut == 1) ? {32'h0, if_b.HRDATA} : if_c.HRDATA;
  assign w_hready = !t_hready_low && o_ready;

  assign if_a.HSEL = t_sel && (t_dut == 0);
  assign if_b.HSEL = t_sel && (t_dut == 1);
  assign if_c.HSEL = t_sel && (t_dut == 2);
  assign if_a.HADDR = t_addr;   assign if_b.HADDR = t_addr;   assign if_c.HADDR = t_addr;
  assign if_a.HTRANS = t_trans; assign if_b.HTRANS = t_trans; assign if_c.HTRANS = t_trans;
  assign if_a.HWRITE = t_write; assign if_b.HWRITE = t_write; assign if_c.HWRITE = t_write;
  assign if_a.HSIZE = t_size;   assign if_b.HSIZE = t_size;   assign if_c.HSIZE = t_size;
  assign if_a.HBURST = t_burst; assign if_b.HBURST = t_burst; assign if_c.HBURST = t_burst;
  assign if_a.HPROT = 4'h3;     assign if_b.HPROT = 4'h3;     assign if_c.HPROT = 4'h3;
  assign if_a.HMASTLOCK = 1'b0; assign if_b.HMASTLOCK = 1'b0; assign if_c.HMASTLOCK = 1'b0;
  assign if_a.HWDATA = t_wdata[31:0];
  assign if_b.HWDATA = t_wdata[31:0];
  assign if_c.HWDATA = t_wdata;
  assign if_a.HREADY = w_hready; assign if_b.HREADY = w_hready; assign if_c.HREADY = w_hready;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %h expected %h", g_tag, tag, obs, expv);
    end
  endtask

  function automatic xfer_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                               input logic [63:0] val, input int nb);
    xfer_t x;
    x.wr    = wr;
    x.addr  = addr;
    x.size  = size;
    x.trans = 2'd2;
    x.wdata = val << (8 * (addr % nb));
    return x;
  endfunction

  // Spec rules: size above bus width, address not a multiple of the size,
  // or byte offset beyond 256 words.
  function automatic bit mdl_err(input int nb, input xfer_t x);
    int lg = (nb == 8) ? 3 : 2;
    if (int'(x.size) > lg) return 1'b1;
    if ((x.addr & ((32'd1 << x.size) - 32'd1)) != 32'd0) return 1'b1;
    if (x.addr >= 32'(256 * nb)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic finish_xfer(input int dut, input int nb, input int ws, input xfer_t x,
                             input int waits, input bit p_or, input bit p_last,
                             input logic [63:0] dat, input logic [63:0] other);
    logic [63:0] ew;
    int base;
    if (!x.trans[1]) begin
      chk("idle_waits", 64'(waits), 64'd0);
      chk("idle_resp", {63'd0, p_last}, 64'd0);
      chk("idle_rdata", dat, 64'd0);
    end else if (mdl_err(nb, x)) begin
      chk("err_waits", 64'(waits), 64'd1);
      chk("err1_resp", {63'd0, p_or}, 64'd1);
      chk("err2_resp", {63'd0, p_last}, 64'd1);
      chk("err_rdata", dat | other, 64'd0);
    end else begin
      chk("ok_waits", 64'(waits), 64'(ws));
      chk("ok_resp", {62'd0, p_or, p_last}, 64'd0);
      chk("ok_wait_rdata", other, 64'd0);
      if (x.wr) begin
        for (int i = 0; i < (1 << x.size); i++) begin
          int a = int'(x.addr) + i;
          mdl[dut][a] = x.wdata[8 * (a % nb) +: 8];
        end
        chk("wr_rdata", dat, 64'd0);
      end else begin
        ew   = '0;
        base = int'(x.addr) & ~(nb - 1);
        for (int l = 0; l < nb; l++) ew[8*l +: 8] = mdl[dut][base + l];
        chk("rd_data", dat, ew);
        g_last_rd = dat;
      end
    end
  endtask

  task automatic drive_addr(input bit have, input xfer_t a);
    if (have) begin
      t_sel   = 1'b1;
      t_addr  = a.addr;
      t_trans = a.trans;
      t_write = a.wr;
      t_size  = a.size;
      t_burst = 3'($urandom_range(0, 7));
    end else begin
      t_sel   = 1'b0;
      t_trans = 2'd0;
    end
  endtask

  // Pipelined master: issues everything in q back to back. Entered and left
  // 1 time unit after a rising edge.
  task automatic run(input int dut);
    int nb, ws, waits, cnt;
    xfer_t a, d;
    bit have_a, have_d, r, p, p_or;
    logic [63:0] dat, other;
    nb = (dut == 2) ? 8 : 4;
    ws = (dut == 1) ? 3 : 0;
    t_dut  = dut;
    have_a = 1'b0;
    have_d = 1'b0;
    a = '0;
    d = '0;
    if (q.size() > 0) begin a = q.pop_front(); have_a = 1'b1; end
    drive_addr(have_a, a);
    waits = 0; cnt = 0; p_or = 1'b0; other = '0;
    while ((have_a || have_d) && cnt < 4000) begin
      @(negedge HCLK);
      r = o_ready; p = o_resp; dat = o_rdata;
      if (!r) begin waits++; p_or |= p; other |= dat; end
      @(posedge HCLK); #1;
      cnt++;
      if (r) begin
        if (have_d) finish_xfer(dut, nb, ws, d, waits, p_or, p, dat, other);
        have_d = have_a;
        d      = a;
        have_a = 1'b0;
        if (q.size() > 0) begin a = q.pop_front(); have_a = 1'b1; end
        drive_addr(have_a, a);
        t_wdata = have_d ? d.wdata : 64'h0;
        waits = 0; p_or = 1'b0; other = '0;
      end
    end
    chk("run_bounded", {63'd0, have_a || have_d}, 64'd0);
  endtask

  initial begin
    int nb;
    xfer_t x;
    HRESET = 1'b1; t_sel = 1'b0; t_addr = '0; t_trans = 2'd0; t_write = 1'b0;
    t_size = 3'd2; t_burst = 3'd0; t_wdata = '0; t_hready_low = 1'b0; t_dut = 0;
    repeat (2) @(posedge HCLK);
    #1;
    g_tag = "reset";
    for (int k = 0; k < 3; k++) begin
      t_dut = k;
      #1;
      chk("hreadyout", {63'd0, o_ready}, 64'd1);
      chk("hresp", {63'd0, o_resp}, 64'd0);
      chk("hrdata", o_rdata, 64'd0);
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    g_tag = "fill";
    for (int k = 0; k < 3; k++) begin
      nb = (k == 2) ? 8 : 4;
      for (int w = 0; w < 16; w++)
        q.push_back(mk(1'b1, 32'(w * nb), (nb == 8) ? 3'd3 : 3'd2, {$urandom, $urandom}, nb));
      run(k);
    end

    g_tag = "basic";
    q.push_back(mk(1'b1, 32'h10, 3'd2, 64'hDEADBEEF, 4));
    q.push_back(mk(1'b0, 32'h10, 3'd2, 64'h0, 4));
    run(0);
    chk("deadbeef", g_last_rd, 64'hDEADBEEF);

    g_tag = "midreset";
    q.push_back(mk(1'b1, 32'h40, 3'd2, 64'h11223344, 4));
    run(1);
    t_dut = 1; t_sel = 1'b1; t_addr = 32'h40; t_trans = 2'd2; t_write = 1'b1; t_size = 3'd2;
    @(posedge HCLK); #1;
    t_sel = 1'b0; t_trans = 2'd0; t_wdata = 64'hCAFEF00D;
    @(negedge HCLK);
    chk("in_wait", {63'd0, o_ready}, 64'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    #1;
    chk("hreadyout", {63'd0, o_ready}, 64'd1);
    chk("hresp", {63'd0, o_resp}, 64'd0);
    chk("hrdata", o_rdata, 64'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    q.push_back(mk(1'b0, 32'h40, 3'd2, 64'h0, 4));
    run(1);
    chk("write_dropped", g_last_rd, 64'h11223344);

    g_tag = "bytelane";
    q.push_back(mk(1'b1, 32'h20, 3'd2, 64'h0, 4));
    q.push_back(mk(1'b1, 32'h22, 3'd0, 64'hAA, 4));
    q.push_back(mk(1'b1, 32'h20, 3'd1, 64'h5566, 4));
    q.push_back(mk(1'b0, 32'h20, 3'd2, 64'h0, 4));
    run(0);
    chk("word", g_last_rd, 64'h00AA5566);

    g_tag = "waitstates";
    q.push_back(mk(1'b0, 32'h0, 3'd2, 64'h0, 4));
    q.push_back(mk(1'b0, 32'h4, 3'd2, 64'h0, 4));
    run(1);

    g_tag = "errors";
    q.push_back(mk(1'b1, 32'h02, 3'd2, 64'h12345678, 4));
    q.push_back(mk(1'b0, 32'd1024, 3'd2, 64'h0, 4));
    q.push_back(mk(1'b0, 32'h0, 3'd3, 64'h0, 4));
    q.push_back(mk(1'b0, 32'h0, 3'd2, 64'h0, 4));
    run(0);

    g_tag = "raw64";
    q.push_back(mk(1'b1, 32'h8, 3'd3, 64'h0123456789ABCDEF, 8));
    q.push_back(mk(1'b0, 32'h8, 3'd3, 64'h0, 8));
    run(2);
    chk("dword", g_last_rd, 64'h0123456789ABCDEF);

    g_tag = "idlebusy";
    x = mk(1'b1, 32'h20, 3'd2, 64'hFFFFFFFF, 4); x.trans = 2'd0; q.push_back(x);
    x.trans = 2'd1; q.push_back(x);
    run(0);
    t_dut = 0; t_hready_low = 1'b1; t_sel = 1'b1; t_trans = 2'd2; t_write = 1'b1;
    t_addr = 32'h20; t_size = 3'd2; t_wdata = 64'hFFFFFFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge HCLK);
      chk("hready_low_ready", {63'd0, o_ready}, 64'd1);
      chk("hready_low_resp", {63'd0, o_resp}, 64'd0);
      @(posedge HCLK); #1;
    end
    t_sel = 1'b0; t_trans = 2'd0; t_hready_low = 1'b0;
    q.push_back(mk(1'b0, 32'h20, 3'd2, 64'h0, 4));
    run(0);
    chk("unchanged", g_last_rd, 64'h00AA5566);

    g_tag = "random";
    for (int k = 0; k < 3; k++) begin
      int lg;
      nb = (k == 2) ? 8 : 4;
      lg = (k == 2) ? 3 : 2;
      for (int n = 0; n < 40; n++) begin
        x.trans = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
        x.wr    = 1'($urandom_range(0, 1));
        x.size  = 3'($urandom_range(0, lg));
        x.addr  = 32'($urandom_range(0, 16 * nb - 1)) & ~((32'd1 << x.size) - 32'd1);
        case ($urandom_range(0, 11))
          0: x.addr = x.addr + 32'(256 * nb);
          1: x.size = 3'(lg + 1);
          2: if (x.size != 3'd0) x.addr = x.addr | 32'd1;
          default: ;
        endcase
        x.wdata = {$urandom, $urandom};
        q.push_back(x);
      end
      run(k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
